// File: rtl/prog_mem_responder.sv
// Program-memory read responder for the fetch stage.
// Returns one instruction word per fetch address with a single cycle of
// read latency.
// Optional feature macro: PROG_MEM_LOADER_EN builds a byte-stream boot
// loader that fills memory while holding the core. When the macro is not
// defined, memory is read-only and the loader outputs are tied low.
module prog_mem_responder #(
  parameter int                     ADDR_WIDTH  = 14,
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     DEPTH       = 16384,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'h0000,
  parameter string                  INIT_FILE   = ""
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [ADDR_WIDTH-1:0]  prog_mem_fetch_read_addr,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   load_start,
  input  logic [7:0]             load_byte,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   cpu_hold
);

  // Index width large enough to address every stored word.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // NOTE: the storage array has no reset; its contents survive a reset so
  // that words written by the loader are retained.
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   addr_in_range;
  logic [IDX_W-1:0]       rd_idx;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;

  assign addr_in_range = (32'(prog_mem_fetch_read_addr) < DEPTH);
  assign rd_idx        = prog_mem_fetch_read_addr[IDX_W-1:0];

  // Registered read: sample the address, hold on stall, flush while held.
  // NOTE: sequential state is always assigned with <= so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (cpu_hold) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= 1'b1;
      if (addr_in_range) instr_q <= mem[rd_idx];
      else               instr_q <= NOP_INSTR;
    end
  end

  // The hold overrides the read register in the very cycle it is raised.
  assign instr_out   = cpu_hold ? NOP_INSTR : instr_q;
  assign instr_valid = valid_q && !cpu_hold;

`ifdef PROG_MEM_LOADER_EN

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_DONE
  } load_state_e;

  load_state_e      state;
  load_state_e      next_state;
  logic [7:0]       len_lo;
  logic [7:0]       data_lo;
  logic [13:0]      words_left;
  logic [13:0]      len_word;
  logic [IDX_W-1:0] wr_addr;
  logic             mem_we;

  // Word count is little-endian; the top two bits of the high byte are dropped.
  assign len_word = {load_byte[5:0], len_lo};

  // Loader state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Loader next-state logic and Moore outputs.
  // NOTE: every output gets a default before the case so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    cpu_hold   = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_start) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) next_state = (len_word == 14'd0) ? S_DONE : S_DATA_LO;
      end
      S_DATA_LO: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) next_state = S_DATA_HI;
      end
      S_DATA_HI: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) begin
          mem_we     = 1'b1;
          next_state = (words_left == 14'd1) ? S_DONE : S_DATA_LO;
        end
      end
      S_DONE: begin
        load_done  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Loader datapath: captured low bytes, remaining word count, write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_lo     <= 8'd0;
      data_lo    <= 8'd0;
      words_left <= 14'd0;
      wr_addr    <= '0;
    end else begin
      unique case (state)
        S_IDLE:    if (load_start) wr_addr <= '0;
        S_LEN_LO:  if (load_valid) len_lo <= load_byte;
        S_LEN_HI:  if (load_valid) words_left <= len_word;
        S_DATA_LO: if (load_valid) data_lo <= load_byte;
        S_DATA_HI: begin
          if (load_valid) begin
            words_left <= words_left - 14'd1;
            wr_addr    <= (wr_addr == IDX_W'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port: a word is committed on the edge that accepts its high byte.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_addr] <= {load_byte, data_lo};
  end

`else

  assign load_ready = 1'b0;
  assign load_done  = 1'b0;
  assign cpu_hold   = 1'b0;

  // Loader inputs have no function in the read-only build.
  logic unused_load;
  assign unused_load = &{1'b0, load_start, load_byte, load_valid};

`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed testbench for prog_mem_responder.
// Covers reset state, read latency, stall hold, out-of-range addresses,
// asynchronous reset and, when PROG_MEM_LOADER_EN is defined, the loader.
module tb_prog_mem_responder;

  localparam logic [15:0] NOP   = 16'hF00F;
  localparam int          DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [13:0] addr = 14'd0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;

  int tests = 0;
  int fails = 0;

  prog_mem_responder #(
    .ADDR_WIDTH (14),
    .INSTR_WIDTH(16),
    .DEPTH      (DEPTH),
    .NOP_INSTR  (NOP),
    .INIT_FILE  ("")
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .stall                   (stall),
    .prog_mem_fetch_read_addr(addr),
    .instr_out               (instr_out),
    .instr_valid             (instr_valid),
    .load_start              (load_start),
    .load_byte               (load_byte),
    .load_valid              (load_valid),
    .load_ready              (load_ready),
    .load_done               (load_done),
    .cpu_hold                (cpu_hold)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    reset = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL release_valid: got %b want 0", instr_valid); end
  endtask

`ifdef PROG_MEM_LOADER_EN
  // Present one byte; it must be accepted on the next edge while the core is held.
  task automatic send_byte(input logic [7:0] b);
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL byte_ready(%h): got %b want 1", b, load_ready); end
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL byte_hold(%h): got %b want 1", b, cpu_hold); end
    load_byte  = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Fill mem[0..3] with 1111,2222,3333,4444 through the loader.
  task automatic preload();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h44);
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL preload_done: got %b want 1", load_done); end
    tick();
  endtask
`endif

  task automatic test_read();
    addr = 14'd0;
    tick();
    tests++; if (instr_out !== 16'h1111) begin fails++; $display("FAIL read0: got %h want 1111", instr_out); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL read0_valid: got %b want 1", instr_valid); end
    addr = 14'd1;
    tick();
    tests++; if (instr_out !== 16'h2222) begin fails++; $display("FAIL read1: got %h want 2222", instr_out); end
    addr = 14'd2;
    tick();
    tests++; if (instr_out !== 16'h3333) begin fails++; $display("FAIL read2: got %h want 3333", instr_out); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    addr  = 14'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (instr_out !== 16'h3333) begin fails++; $display("FAIL stall_hold[%0d]: got %h want 3333", i, instr_out); end
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
    end
    stall = 1'b0;
    tick();
    tests++; if (instr_out !== 16'h4444) begin fails++; $display("FAIL stall_release: got %h want 4444", instr_out); end
  endtask

  task automatic test_range();
`ifndef PROG_MEM_LOADER_EN
    addr = 14'(DEPTH - 1);
    tick();
    tests++; if (instr_out !== 16'h5A5A) begin fails++; $display("FAIL range_last: got %h want 5a5a", instr_out); end
`endif
    addr = 14'(DEPTH);
    tick();
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL range_depth: got %h want %h", instr_out, NOP); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL range_valid: got %b want 1", instr_valid); end
    addr = 14'h3FFF;
    tick();
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL range_max: got %h want %h", instr_out, NOP); end
    addr = 14'd0;
    tick();
    tests++; if (instr_out !== 16'h1111) begin fails++; $display("FAIL range_recover: got %h want 1111", instr_out); end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL async_reset_instr: got %h want %h", instr_out, NOP); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b want 0", instr_valid); end
    #1;
    reset = 1'b0;
    tick();
    tests++; if (instr_out !== 16'h1111) begin fails++; $display("FAIL async_reset_reread: got %h want 1111", instr_out); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL async_reset_revalid: got %b want 1", instr_valid); end
  endtask

`ifdef PROG_MEM_LOADER_EN
  task automatic test_load_basic();
    addr       = 14'd0;
    stall      = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL load_hold_start: got %b want 1", cpu_hold); end
    tests++; if (instr_out !== NOP) begin fails++; $display("FAIL load_hold_instr: got %h want %h", instr_out, NOP); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL load_hold_valid: got %b want 0", instr_valid); end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hCD); send_byte(8'hAB);
    send_byte(8'h34);
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL load_done_early: got %b want 0", load_done); end
    send_byte(8'h12);
    stall = 1'b0;
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL load_done_pulse: got %b want 1", load_done); end
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL load_hold_drop: got %b want 0", cpu_hold); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL load_done_valid: got %b want 0", instr_valid); end
    tick();
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL load_done_once: got %b want 0", load_done); end
    tests++; if (instr_out !== 16'hABCD) begin fails++; $display("FAIL load_read0: got %h want abcd", instr_out); end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL load_read0_valid: got %b want 1", instr_valid); end
    addr = 14'd1;
    tick();
    tests++; if (instr_out !== 16'h1234) begin fails++; $display("FAIL load_read1: got %h want 1234", instr_out); end
  endtask

  task automatic test_load_empty();
    addr       = 14'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h00);
    load_start = 1'b1;
    send_byte(8'h00);
    load_start = 1'b0;
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL empty_done: got %b want 1", load_done); end
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL empty_hold: got %b want 0", cpu_hold); end
    tick();
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL empty_done_once: got %b want 0", load_done); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL empty_idle_ready: got %b want 0", load_ready); end
    tests++; if (instr_out !== 16'hABCD) begin fails++; $display("FAIL empty_no_write: got %h want abcd", instr_out); end
  endtask

  task automatic test_load_reset();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL midload_hold: got %b want 1", cpu_hold); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL midload_reset_hold: got %b want 0", cpu_hold); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL midload_reset_ready: got %b want 0", load_ready); end
    #1;
    reset = 1'b0;
    addr  = 14'd0;
    tick();
    tests++; if (instr_out !== 16'h5678) begin fails++; $display("FAIL midload_retained: got %h want 5678", instr_out); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL midload_idle: got %b want 0", load_ready); end
  endtask
`else
  task automatic test_loader_off();
    addr       = 14'd0;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      load_start = 1'b0;
      tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL off_ready[%0d]: got %b want 0", i, load_ready); end
      tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL off_done[%0d]: got %b want 0", i, load_done); end
      tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL off_hold[%0d]: got %b want 0", i, cpu_hold); end
      tests++; if (instr_out !== 16'h1111) begin fails++; $display("FAIL off_read[%0d]: got %h want 1111", i, instr_out); end
    end
    load_valid = 1'b0;
  endtask
`endif

  // Bound total run time so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef PROG_MEM_LOADER_EN
    dut.mem[0]         = 16'h1111;
    dut.mem[1]         = 16'h2222;
    dut.mem[2]         = 16'h3333;
    dut.mem[3]         = 16'h4444;
    dut.mem[DEPTH - 1] = 16'h5A5A;
`endif
    test_reset();
`ifdef PROG_MEM_LOADER_EN
    preload();
`endif
    test_read();
    test_stall();
    test_range();
    test_async_reset();
`ifdef PROG_MEM_LOADER_EN
    test_load_basic();
    test_load_empty();
    test_load_reset();
`else
    test_loader_off();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
